// File: rtl/fifo_read_port_if.sv
// Read-port bundle: FIFO-side pop/empty/data plus the downstream valid/ready stream.
interface fifo_read_port_if #(
    parameter int unsigned width = 8
);
    logic             empty;
    logic [width-1:0] rd_data;
    logic             read;
    logic [width-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       level;

    modport master (
        input  empty, rd_data, out_ready,
        output read, out_data, out_valid, level
    );

    modport slave (
        output empty, rd_data, out_ready,
        input  read, out_data, out_valid, level
    );
endinterface

// File: rtl/fifo_read_port.sv
// FIFO read-side consumer: pops the RAM-backed FIFO and re-times the late read data
// into a 2-entry skid buffer feeding a valid/ready stream.
module fifo_read_port #(
    parameter int unsigned width = 8
) (
    input logic               clk,
    input logic               reset,
    fifo_read_port_if.master  bus
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } occ_e;

    occ_e             state_q;
    logic             inflight_q;
    logic             valid_q;
    logic [width-1:0] head_q;
    logic [width-1:0] tail_q;

    logic       pop;
    logic       push;
    logic       read_c;
    logic [2:0] demand;

    assign pop  = valid_q & bus.out_ready;
    assign push = inflight_q;

    // Slots still claimed after this cycle's pop; a new read is safe only below two.
    assign demand = {1'b0, state_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign read_c = ~reset & ~bus.empty & (demand < 3'd2);

    assign bus.read      = read_c;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = head_q;
    assign bus.level     = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StEmpty;
            inflight_q <= 1'b0;
            valid_q    <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            inflight_q <= read_c;
            case (state_q)
                StEmpty: begin
                    if (push) begin
                        state_q <= StOne;
                        head_q  <= bus.rd_data;
                        valid_q <= 1'b1;
                    end
                end
                StOne: begin
                    if (push && !pop) begin
                        state_q <= StTwo;
                        tail_q  <= bus.rd_data;
                    end else if (push && pop) begin
                        head_q <= bus.rd_data;
                    end else if (pop) begin
                        state_q <= StEmpty;
                        valid_q <= 1'b0;
                    end
                end
                StTwo: begin
                    // No push can land here: reads are throttled so a returning word has a slot.
                    if (pop) begin
                        state_q <= StOne;
                        head_q  <= tail_q;
                    end
                end
                default: begin
                    state_q <= StEmpty;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fifo_read_port.md
Name: fifo_read_port

Overview:
- Read-side consumer for the RAM-backed FIFO.
- Watches the FIFO controller's empty flag and issues single-cycle read (pop) strobes.
- Captures the RAM read data, which arrives one cycle late, into a 2-entry output buffer.
- Presents that data downstream on a valid/ready handshake, so a downstream stall never loses words and full one-word-per-cycle throughput is sustained.

Parameters:
- width, 8, data word width in bits; must match the FIFO RAM data width.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- empty  input  1  FIFO controller empty flag.
- rd_data  input  width  RAM read data; valid in the cycle after read was asserted.
- read  output  1  pop strobe to the FIFO controller; one word per cycle asserted.
- out_data  output  width  head word of the output buffer.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts out_data this cycle.
- level  output  2  words currently held in the output buffer (0..2).

Behaviour:
- Reset (async, active-high):
  - Clears the buffer, the in-flight flag, level=0, out_valid=0 and out_data=0 immediately, without waiting for a clock edge.
  - read=0 while reset is high.
- State: 2-entry buffer (head, tail), occupancy occ in {0,1,2}, 1-bit register inflight.
  - inflight <= read every cycle.
  - level = occ; out_valid = (occ != 0); out_data = head.
- pop = out_valid & out_ready. pop is the downstream handshake, distinct from read.
- read (combinational from registered state, empty, and out_ready):
  - read = ~reset & ~empty & (occ + inflight - pop < 2).
  - Invariant: occ + inflight <= 2 at every edge, so a returning word always has a slot.
- push = inflight: rd_data is captured on the edge that ends the cycle in which inflight=1.
- Occupancy state machine, per edge:
  - EMPTY (occ=0):
    - push -> ONE, head<=rd_data.
    - Otherwise stay.
    - pop cannot occur here.
  - ONE (occ=1):
    - push & ~pop -> TWO, tail<=rd_data.
    - push & pop -> ONE, head<=rd_data.
    - ~push & pop -> EMPTY.
    - Otherwise stay.
  - TWO (occ=2):
    - pop -> ONE, head<=tail.
    - ~pop -> stay.
    - push never occurs here; the invariant guarantees this.
- Latency: read asserted in cycle t -> word captured at end of t+1 -> out_valid=1 in t+2 when the buffer was empty.
- Throughput: with out_ready held at 1 and empty=0, read stays asserted continuously and one word per cycle is delivered.
- Ordering: words leave strictly in the order read; no duplication, no drop.
- Stall: with out_ready=0, read is issued until occ + inflight = 2, then read=0 until a pop.
  - out_data and out_valid hold stable while out_valid=1 and out_ready=0.
- FIFO empty:
  - read=0 regardless of buffer space.
  - Buffered words keep draining normally.
- Reset mid-operation:
  - Buffered and in-flight words are discarded.
  - rd_data arriving in the cycle after reset deasserts is ignored, because inflight was cleared.
- Do not assume empty falls the same cycle as read; honour empty as sampled each cycle.

Test Plan:
- Reset then empty=1 for 5 cycles -> read=0, out_valid=0, level=0 throughout; assert reset mid-cycle -> outputs clear before the next edge.
- Write 0x11,0x22,0x33 into the FIFO, out_ready=1 -> read pulses 3 consecutive cycles.
  - out_data shows 0x11,0x22,0x33 on consecutive cycles, first valid 2 cycles after the first read.
  - Then out_valid=0 and level=0.
- FIFO holds 5 words, out_ready=0 -> exactly 2 read pulses, then read=0 and level=2, with out_data=first word held stable.
  - Raise out_ready -> all 5 words emerge in order with no gaps after the restart.
- out_ready toggling 1,0,1,0 with FIFO holding 6 words 0xA0..0xA5 -> every word delivered once, in order.
  - occ + inflight never exceeds 2 (bench assertion).
- Reset asserted while level=2 and inflight=1 -> level=0 and out_valid=0 immediately.
  - After release, no stale word appears and the next FIFO word is delivered first.
- FIFO receives a single word 0x5A while the buffer is empty and out_ready=1 -> one read pulse, out_valid high for exactly one cycle with 0x5A, then idle.
